// File: rtl/cpu_fetch_sequencer_pkg.sv
// cpu_fetch_sequencer_pkg: shared opcode match constants, PC mux encodings and types
// for the PIC10-compatible fetch sequencer.
//   state_e    - sequencer FSM states
//   pc_sel_e   - PC mux select encodings
//   decode_t   - branch-decode result bundle
package cpu_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_RUN,
        ST_SLEEP
    } state_e;

    typedef enum logic [1:0] {
        SEL_IMM   = 2'b00,
        SEL_STACK = 2'b01,
        SEL_ALU   = 2'b10,
        SEL_RSVD  = 2'b11
    } pc_sel_e;

    typedef struct packed {
        logic is_goto;
        logic is_call;
        logic is_retlw;
        logic is_skip;
        logic is_sleep;
    } decode_t;

    localparam logic [11:0] NOP       = 12'h000;
    localparam logic [11:0] OP_SLEEP  = 12'h003;
    localparam logic [2:0]  OP_GOTO   = 3'b101;
    localparam logic [3:0]  OP_CALL   = 4'b1001;
    localparam logic [3:0]  OP_RETLW  = 4'b1000;
    localparam logic [3:0]  OP_BTFSC  = 4'b0110;
    localparam logic [3:0]  OP_BTFSS  = 4'b0111;
    localparam logic [5:0]  OP_DECFSZ = 6'b001011;
    localparam logic [5:0]  OP_INCFSZ = 6'b001111;

endpackage

// File: rtl/cpu_fetch_sequencer_if.sv
// cpu_fetch_sequencer_if: handshake bundle between the fetch sequencer and the
// instruction datapath (PC, IR, NOP mux, PC mux, return stack).
//   master - sequencer side: consumes IR/execute status, drives strobes
//   slave  - datapath side: drives IR/execute status, consumes strobes
interface cpu_fetch_sequencer_if;
    logic [11:0] instruction_reg_out;
    logic        skip_condition;
    logic        pcl_write;
    logic        hold;
    logic        wake;
    logic        nop_insert;
    logic        load_instruction;
    logic [1:0]  pc_mux_select;
    logic        load_pc;
    logic        inc_pc;
    logic        inc_stack;
    logic        dec_stack;
    logic        load_stack;
    logic [2:0]  stack_level;
    logic        stack_overflow;
    logic        stack_underflow;
    logic        sleeping;

    modport master (
        input  instruction_reg_out, skip_condition, pcl_write, hold, wake,
        output nop_insert, load_instruction, pc_mux_select, load_pc, inc_pc,
               inc_stack, dec_stack, load_stack, stack_level,
               stack_overflow, stack_underflow, sleeping
    );

    modport slave (
        output instruction_reg_out, skip_condition, pcl_write, hold, wake,
        input  nop_insert, load_instruction, pc_mux_select, load_pc, inc_pc,
               inc_stack, dec_stack, load_stack, stack_level,
               stack_overflow, stack_underflow, sleeping
    );
endinterface

// File: rtl/cpu_fetch_sequencer_branch_decode.sv
// cpu_fetch_sequencer_branch_decode: combinational IR classifier.
//   ir_i  - instruction register contents
//   dec_o - goto/call/retlw/skip/sleep flags
module cpu_fetch_sequencer_branch_decode
    import cpu_fetch_sequencer_pkg::*;
(
    input  logic [11:0] ir_i,
    output decode_t     dec_o
);
    always_comb begin
        dec_o.is_goto  = ir_i[11:9] == OP_GOTO;
        dec_o.is_call  = ir_i[11:8] == OP_CALL;
        dec_o.is_retlw = ir_i[11:8] == OP_RETLW;
        dec_o.is_skip  = ir_i[11:6] == OP_DECFSZ || ir_i[11:6] == OP_INCFSZ ||
                         ir_i[11:8] == OP_BTFSC  || ir_i[11:8] == OP_BTFSS;
        dec_o.is_sleep = ir_i == OP_SLEEP;
    end
endmodule

// File: rtl/cpu_fetch_sequencer.sv
// cpu_fetch_sequencer: fetch/execute control FSM for the PIC10-compatible core.
//   clk, rst - core clock, asynchronous active-high reset
//   ctl      - datapath bundle (master side): IR and execute status in,
//              IR/PC/stack strobes, stack depth, error flags and sleep status out
module cpu_fetch_sequencer
    import cpu_fetch_sequencer_pkg::*;
#(
    parameter int STACK_DEPTH        = 2,
    parameter int RESET_FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_fetch_sequencer_if.master ctl
);
    state_e     state_q, state_d;
    logic [1:0] flush_q, flush_d;
    logic [2:0] level_q, level_d;
    logic       ovf_q, ovf_d, unf_q, unf_d;
    decode_t    dec;
    logic       run, flush, pcl_w, br, sk, sl, full;

    cpu_fetch_sequencer_branch_decode u_decode (
        .ir_i  (ctl.instruction_reg_out),
        .dec_o (dec)
    );

    always_comb begin
        // strobes are gated by rst so nothing fires while reset is held
        run   = state_q == ST_RUN && !ctl.hold && !rst;
        flush = state_q == ST_FLUSH && !ctl.hold && !rst;
        // a PCL write only redirects when the opcode is not already a branch
        pcl_w = ctl.pcl_write && !(dec.is_goto || dec.is_call || dec.is_retlw);
        br    = run && (dec.is_goto || dec.is_call || dec.is_retlw || pcl_w);
        sk    = run && dec.is_skip && ctl.skip_condition && !pcl_w;
        sl    = run && dec.is_sleep && !pcl_w;
        full  = level_q == 3'(STACK_DEPTH);
        ctl.load_instruction = flush || run;
        ctl.nop_insert       = flush || br || sk || sl;
        ctl.load_pc          = br;
        ctl.inc_pc           = run && !br && !sl;
        ctl.pc_mux_select    = !br ? SEL_IMM : dec.is_retlw ? SEL_STACK : pcl_w ? SEL_ALU : SEL_IMM;
        ctl.inc_stack        = run && dec.is_call;
        ctl.load_stack       = run && dec.is_call;
        ctl.dec_stack        = run && dec.is_retlw;
        ctl.stack_level      = level_q;
        ctl.stack_overflow   = ovf_q;
        ctl.stack_underflow  = unf_q;
        ctl.sleeping         = state_q == ST_SLEEP;
        state_d = ctl.hold ? state_q :
                  state_q == ST_FLUSH ? (flush_q <= 2'd1 ? ST_RUN : ST_FLUSH) :
                  state_q == ST_SLEEP ? (ctl.wake ? ST_RUN : ST_SLEEP) :
                  sl ? ST_SLEEP : ST_RUN;
        flush_d = flush ? flush_q - 2'd1 : flush_q;
        // pushes saturate at full depth and pops at zero; the branch itself is still taken
        level_d = ctl.inc_stack && !full ? level_q + 3'd1 :
                  ctl.dec_stack && level_q != 3'd0 ? level_q - 3'd1 : level_q;
        ovf_d   = ovf_q || (ctl.inc_stack && full);
        unf_d   = unf_q || (ctl.dec_stack && level_q == 3'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FLUSH;
            flush_q <= 2'(RESET_FLUSH_CYCLES);
            level_q <= 3'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
endmodule

// File: doc/cpu_fetch_sequencer.md
Name: cpu_fetch_sequencer

Overview:
- Control FSM for the instruction datapath (PC, instruction register, NOP mux, PC mux, 2-level return stack) of the PIC10-compatible core.
- Decodes the instruction register each cycle and drives fetch/flush/branch/stack strobes.
- Implements a 2-stage overlapped fetch/execute pipeline, skip handling, SLEEP/wake, external hold and stack-depth tracking with sticky error flags.

Parameters:
STACK_DEPTH, 2, number of return-stack entries tracked by the depth counter (1..4).
RESET_FLUSH_CYCLES, 1, cycles of forced NOP fetch after reset release (1..3).

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
instruction_reg_out  input  12  current IR contents (instruction in execute)
skip_condition  input  1  execute-stage result: skip taken (zero result or bit test true)
pcl_write  input  1  executing instruction writes PCL (computed jump via ALU)
hold  input  1  freeze pipeline (debug/bus wait); no strobes asserted
wake  input  1  leave SLEEP
nop_insert  output  1  force NOP into IR on this load
load_instruction  output  1  IR load enable
pc_mux_select  output  2  00 instruction[8:0], 01 stack, 10 alu_output, 11 reserved
load_pc  output  1  PC load from mux
inc_pc  output  1  PC increment
inc_stack  output  1  push pointer advance
dec_stack  output  1  pop pointer retreat
load_stack  output  1  write PC to stack top
stack_level  output  3  current tracked depth 0..STACK_DEPTH
stack_overflow  output  1  sticky: push at full depth
stack_underflow  output  1  sticky: pop at depth 0
sleeping  output  1  high in SLEEP state

Behaviour:
- Reset (async): state=FLUSH, flush counter=RESET_FLUSH_CYCLES, stack_level=0, both error flags=0, all strobes 0, pc_mux_select=00, sleeping=0.
- Outputs are combinational from state + IR decode; only state, flush counter, stack_level and flags are registered.
- States: FLUSH, RUN, SLEEP.
- FLUSH: load_instruction=1, nop_insert=1, inc_pc=0; counter decrements; at 1 -> RUN. PC stays 0 so first real fetch is address 0.
- RUN, normal: load_instruction=1, inc_pc=1. Throughput 1 instruction/cycle.
- GOTO (IR[11:9]=101): load_pc=1, sel=00, load_instruction=1, nop_insert=1, inc_pc=0. 2-cycle cost.
- CALL (IR[11:8]=1001): as GOTO plus load_stack=1, inc_stack=1 (PC already points at CALL+1). stack_level+1; at full: stays full, stack_overflow<=1 (entry wraps, PIC behaviour).
- RETLW (IR[11:8]=1000): load_pc=1, sel=01, dec_stack=1, nop_insert=1, load_instruction=1. stack_level-1; at 0: stays 0, stack_underflow<=1, branch still taken.
- pcl_write (non-branch opcode): load_pc=1, sel=10, flush as GOTO. Ignored if IR is GOTO/CALL/RETLW.
- Skip ops (DECFSZ 001011, INCFSZ 001111, BTFSC 0110, BTFSS 0111) with skip_condition=1: load_instruction=1, nop_insert=1, inc_pc=1. With skip_condition=0: normal.
- SLEEP (IR=0x003): load_instruction=1, nop_insert=1, inc_pc=0 -> SLEEP. In SLEEP all strobes 0, sleeping=1; wake=1 -> RUN next cycle, execution resumes at PC (SLEEP+1).
- hold=1 (any state except reset): all strobes 0, state/counters frozen; hold dominates every decode, including in FLUSH.
- Invariant: load_pc and inc_pc never both 1; inc_stack and dec_stack never both 1.
- rst mid-branch/mid-sleep: immediate return to reset values; no partial stack update.

Decomposition:
- cpu_pkg: opcode match constants (GOTO, CALL, RETLW, SLEEP, skip masks), pc_mux_select encodings, NOP=12'h000.
- One sub-module: cpu_branch_decode (combinational IR -> is_goto/is_call/is_retlw/is_skip/is_sleep).

Test Plan:
- Reset release, IR=NOP stream -> 1 cycle nop_insert=1/inc_pc=0, then inc_pc=1 each cycle, stack_level=0.
- IR=0xA25 (GOTO 0x025) -> one cycle load_pc=1, sel=00, nop_insert=1, inc_pc=0; next cycle normal.
- CALL 0x910, CALL 0x920, CALL 0x930 -> stack_level 1,2,2; stack_overflow=1 after third; load_stack/inc_stack each CALL.
- RETLW 0x8xx at stack_level 0 -> load_pc=1, sel=01, dec_stack=1, stack_underflow=1, stack_level 0.
- BTFSS (0x7xx) with skip_condition=1 -> nop_insert=1, inc_pc=1, load_pc=0; with 0 -> normal fetch.
- IR=0x003 then wake after 5 cycles, hold=1 during a GOTO -> sleeping=1 with strobes 0 until wake, RUN next cycle; GOTO strobes suppressed while hold, issued once on hold release.
